matrix_scan: RTL



---
 rtl/matrix_scan.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/matrix_scan.sv
// matrix_scan: row-multiplexed renderer for a 16x16 LED matrix.
//
// Draws the ball (one pixel) and two paddles (column 0 and column 15) one row at a
// time. Ball and paddle positions are snapshotted once per frame, on the edge where
// the scan wraps from row 15 to row 0, so a frame never shows a mix of old and new
// positions.
//
// Parameters:
//   DWELL       clk cycles spent on each row (>= 2)
//   BLANK       leading cycles of each row with all drivers off (< DWELL)
//   PADDLE_LEN  paddle height in rows (1..16)
//
// Ports:
//   clk          scan clock; all inputs are synchronous to it
//   reset        asynchronous, active-high; blanks the outputs at once
//   ball_x       ball column, 0 = left
//   ball_y       ball row, 0 = top
//   paddle_l     top row of the left paddle (column 0)
//   paddle_r     top row of the right paddle (column 15)
//   row_sel      row currently driven
//   row_en       row driver enable
//   col          column drive, bit n = column n, active-high
//   frame_start  one-cycle pulse when row 0 begins and the snapshot is taken
//
// Build option:
//   MATRIX_SCAN_DIM_EN  when defined, paddle pixels are lit only during the second
//                       half of each row's on-window (about half brightness). Ball
//                       pixels keep the full on-window.

module matrix_scan #(
    parameter int unsigned DWELL      = 125,
    parameter int unsigned BLANK      = 2,
    parameter int unsigned PADDLE_LEN = 3
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [3:0]  ball_x,
    input  logic [3:0]  ball_y,
    input  logic [3:0]  paddle_l,
    input  logic [3:0]  paddle_r,
    output logic [3:0]  row_sel,
    output logic        row_en,
    output logic [15:0] col,
    output logic        frame_start
);

    localparam int unsigned PW = (DWELL > 2) ? $clog2(DWELL) : 1;

    localparam logic [PW-1:0] PHASE_LAST = PW'(DWELL - 1);
    localparam logic [PW-1:0] PHASE_ON   = PW'(BLANK);
    localparam logic [4:0]    PLEN       = 5'(PADDLE_LEN);
`ifdef MATRIX_SCAN_DIM_EN
    localparam logic [PW-1:0] PHASE_DIM  = PW'(BLANK + (DWELL - BLANK) / 2);
`endif

    // Scan position
    logic [PW-1:0] phase_q, phase_d;
    logic [3:0]    row_q, row_d;

    // Per-frame snapshot of the positions
    logic [3:0] sx_q, sy_q, spl_q, spr_q;

    logic frame_start_q, frame_start_d;

    // Low from reset until the first edge after release. Reset parks the phase on
    // DWELL-1 (which is past the blanking window), so this flag is what keeps the
    // drivers dark while reset is held.
    logic active_q;

    logic row_last;
    logic frame_edge;

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        row_last      = (phase_q == PHASE_LAST);
        frame_edge    = row_last && (row_q == 4'hF);
        phase_d       = row_last ? '0 : phase_q + PW'(1);
        row_d         = row_last ? row_q + 4'd1 : row_q;
        frame_start_d = frame_edge;
    end

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            phase_q       <= PHASE_LAST;
            row_q         <= 4'hF;
            sx_q          <= '0;
            sy_q          <= '0;
            spl_q         <= '0;
            spr_q         <= '0;
            frame_start_q <= 1'b0;
            active_q      <= 1'b0;
        end else begin
            phase_q       <= phase_d;
            row_q         <= row_d;
            frame_start_q <= frame_start_d;
            active_q      <= 1'b1;
            if (frame_edge) begin
                sx_q  <= ball_x;
                sy_q  <= ball_y;
                spl_q <= paddle_l;
                spr_q <= paddle_r;
            end
        end
    end

    // ------------------------------------------------------------------
    // Output decode (registered state only)
    // ------------------------------------------------------------------
    logic [4:0]  row_w;
    logic        on_window;
    logic        pl_hit, pr_hit;
    logic        paddle_lit;
    logic [15:0] ball_col;
    logic [15:0] paddle_col;

    always_comb begin
        // 5-bit compare so a paddle near the bottom is clipped instead of wrapping
        row_w      = {1'b0, row_q};
        pl_hit     = ({1'b0, spl_q} <= row_w) && (row_w < ({1'b0, spl_q} + PLEN));
        pr_hit     = ({1'b0, spr_q} <= row_w) && (row_w < ({1'b0, spr_q} + PLEN));
        on_window  = active_q && (phase_q >= PHASE_ON);
        ball_col   = (row_q == sy_q) ? (16'h0001 << sx_q) : 16'h0000;
        paddle_col = {pr_hit, 14'b0, pl_hit};
`ifdef MATRIX_SCAN_DIM_EN
        paddle_lit = (phase_q >= PHASE_DIM);
`else
        paddle_lit = 1'b1;
`endif
        row_sel     = row_q;
        row_en      = on_window;
        col         = on_window ? (ball_col | (paddle_lit ? paddle_col : 16'h0000)) : 16'h0000;
        frame_start = frame_start_q;
    end

endmodule
